// File: rtl/inst_rom_ldr.sv
// Instruction ROM with a byte-serial program loader; fetch is combinational (zero latency).
// Loader takes one byte per ld_valid cycle while ld_ready; fetch returns NOP while a load is busy.
module inst_rom_ldr #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] addr,
  output logic [31:0] inst,
  input  logic        ld_start,
  input  logic [7:0]  ld_byte,
  input  logic        ld_valid,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        ld_busy,
  output logic        ld_done,
  output logic        ld_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                state;
  logic [DEPTH_LOG2:0]   wptr;
  logic [1:0]            bcnt;
  logic [31:0]           asm_q;
  logic [31:0]           asm_nxt;
  logic [31:0]           mem [DEPTH];
  logic                  full;
  logic                  wr_en;
  logic                  unused_addr;

  assign full = wptr[DEPTH_LOG2];

  // Big-endian lane insert: the first byte of a word lands in bits [31:24].
  always_comb begin
    asm_nxt = asm_q;
    case (bcnt)
      2'd0:    asm_nxt[31:24] = ld_byte;
      2'd1:    asm_nxt[23:16] = ld_byte;
      2'd2:    asm_nxt[15:8]  = ld_byte;
      default: asm_nxt[7:0]   = ld_byte;
    endcase
  end

  // A restart pulse swallows the byte presented alongside it.
  assign wr_en = !rst && (state == LOAD) && !ld_start && ld_valid && !full
                 && ((bcnt == 2'd3) || ld_last);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr[DEPTH_LOG2-1:0]] <= asm_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wptr     <= '0;
      bcnt     <= '0;
      asm_q    <= '0;
      ld_err   <= 1'b0;
      ld_ready <= 1'b0;
      ld_busy  <= 1'b0;
      ld_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_start) begin
            state    <= LOAD;
            wptr     <= '0;
            bcnt     <= '0;
            asm_q    <= '0;
            ld_err   <= 1'b0;
            ld_ready <= 1'b1;
            ld_busy  <= 1'b1;
            ld_done  <= 1'b0;
          end
        end
        LOAD: begin
          if (ld_start) begin
            wptr   <= '0;
            bcnt   <= '0;
            asm_q  <= '0;
            ld_err <= 1'b0;
          end else if (ld_valid) begin
            if (full) begin
              ld_err <= 1'b1;
            end else if ((bcnt == 2'd3) || ld_last) begin
              wptr  <= wptr + 1'b1;
              bcnt  <= '0;
              asm_q <= '0;
            end else begin
              bcnt  <= bcnt + 2'd1;
              asm_q <= asm_nxt;
            end
            if (ld_last) begin
              state    <= DONE;
              ld_ready <= 1'b0;
              ld_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          ld_ready <= 1'b0;
          ld_busy  <= 1'b0;
          ld_done  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          ld_ready <= 1'b0;
          ld_busy  <= 1'b0;
          ld_done  <= 1'b0;
        end
      endcase
    end
  end

  // Byte offset and high address bits are don't-care, so fetches wrap.
  assign inst = (ce && !ld_busy) ? mem[addr[DEPTH_LOG2+1:2]] : 32'h0;

  assign unused_addr = ^{addr[1:0], addr[31:DEPTH_LOG2+2]};

endmodule

// File: tb/tb_inst_rom_ldr.sv
// Bench for inst_rom_ldr: a byte-count model of two instances (1024 and 4 words) plus directed loads.
module tb_inst_rom_ldr;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ce, ld_start, ld_valid, ld_last;
  logic [31:0] addr;
  logic [7:0]  ld_byte;
  logic [31:0] inst_a, inst_b;
  logic        rdy_a, busy_a, done_a, err_a;
  logic        rdy_b, busy_b, done_b, err_b;

  inst_rom_ldr #(.DEPTH_LOG2(10)) dut_a (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_a),
    .ld_start(ld_start), .ld_byte(ld_byte), .ld_valid(ld_valid), .ld_last(ld_last),
    .ld_ready(rdy_a), .ld_busy(busy_a), .ld_done(done_a), .ld_err(err_a)
  );

  inst_rom_ldr #(.DEPTH_LOG2(2)) dut_b (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_b),
    .ld_start(ld_start), .ld_byte(ld_byte), .ld_valid(ld_valid), .ld_last(ld_last),
    .ld_ready(rdy_b), .ld_busy(busy_b), .ld_done(done_b), .ld_err(err_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Model: phase 0=idle 1=loading 2=done; m_n counts bytes accepted in the current load.
  int          m_phase [2];
  int          m_n     [2];
  bit          m_err   [2];
  logic [7:0]  m_pend  [2][4];
  logic [31:0] m_mem   [2][1024];
  bit          m_wr    [2][1024];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int depth_of(input int k);
    return (k == 0) ? 1024 : 4;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int n;
      int lane;
      n = m_n[k];
      if (rst) begin
        m_phase[k] = 0; m_n[k] = 0; m_err[k] = 1'b0;
      end else if (m_phase[k] == 0) begin
        if (ld_start) begin
          m_phase[k] = 1; m_n[k] = 0; m_err[k] = 1'b0;
        end
      end else if (m_phase[k] == 1) begin
        if (ld_start) begin
          m_n[k] = 0; m_err[k] = 1'b0;
        end else if (ld_valid) begin
          if (n >= 4 * depth_of(k)) begin
            m_err[k] = 1'b1;
          end else begin
            lane = n % 4;
            if (lane == 0) for (int j = 0; j < 4; j++) m_pend[k][j] = 8'h00;
            m_pend[k][lane] = ld_byte;
            if (lane == 3 || ld_last) begin
              m_mem[k][n / 4] = {m_pend[k][0], m_pend[k][1], m_pend[k][2], m_pend[k][3]};
              m_wr[k][n / 4]  = 1'b1;
            end
          end
          m_n[k] = n + 1;
          if (ld_last) m_phase[k] = 2;
        end
      end else begin
        m_phase[k] = 0;
      end
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        logic [31:0] idx;
        logic        busy_e;
        busy_e = (m_phase[k] != 0);
        idx    = (addr >> 2) & 32'(depth_of(k) - 1);
        chk(k == 0 ? "a_ready" : "b_ready", {31'b0, k == 0 ? rdy_a : rdy_b}, {31'b0, m_phase[k] == 1});
        chk(k == 0 ? "a_busy" : "b_busy", {31'b0, k == 0 ? busy_a : busy_b}, {31'b0, busy_e});
        chk(k == 0 ? "a_done" : "b_done", {31'b0, k == 0 ? done_a : done_b}, {31'b0, m_phase[k] == 2});
        chk(k == 0 ? "a_err" : "b_err", {31'b0, k == 0 ? err_a : err_b}, {31'b0, m_err[k]});
        if (!(ce && !busy_e))
          chk(k == 0 ? "a_inst_nop" : "b_inst_nop", k == 0 ? inst_a : inst_b, 32'h0);
        else if (m_wr[k][idx])
          chk(k == 0 ? "a_inst" : "b_inst", k == 0 ? inst_a : inst_b, m_mem[k][idx]);
      end
    end
  end

  task automatic align();
    @(posedge clk); #1;
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    align();
    ld_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    ld_valid = 1'b1; ld_byte = b; ld_last = last;
    align();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic finish_load(input string nm);
    @(negedge clk);
    chk({nm, "_done_pulse"}, {31'b0, done_a}, 32'd1);
    align();
    @(negedge clk);
    chk({nm, "_done_clear"}, {31'b0, done_a}, 32'd0);
    align();
  endtask

  task automatic rd(input bit use_b, input logic [31:0] a, input logic [31:0] exp, input string nm);
    ce = 1'b1; addr = a;
    @(negedge clk);
    chk(nm, use_b ? inst_b : inst_a, exp);
    align();
    ce = 1'b0;
  endtask

  initial begin
    logic [7:0] v8 [8];
    logic [7:0] v4 [4];
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_n[k] = 0; m_err[k] = 1'b0;
    end
    rst = 1'b1; ce = 1'b0; addr = '0; ld_start = 1'b0;
    ld_valid = 1'b0; ld_last = 1'b0; ld_byte = '0;

    align();
    @(negedge clk);
    chk("rst_ready", {31'b0, rdy_a}, 32'd0);
    chk("rst_busy", {31'b0, busy_a}, 32'd0);
    chk("rst_done", {31'b0, done_a}, 32'd0);
    chk("rst_err", {31'b0, err_a}, 32'd0);
    chk("rst_inst", inst_a, 32'h0);
    align();
    rst = 1'b0;
    cmp_en = 1'b1;

    // Single word
    start_load();
    send(8'h34, 1'b0); send(8'h01, 1'b0); send(8'h11, 1'b0); send(8'h00, 1'b1);
    finish_load("w1");
    rd(1'b0, 32'd0, 32'h34011100, "w1_addr0");

    // Two words, wrap and byte-offset aliasing
    v8 = '{8'h3C, 8'h01, 8'h01, 8'h01, 8'h34, 8'h21, 8'h01, 8'h00};
    start_load();
    for (int i = 0; i < 8; i++) send(v8[i], i == 7);
    finish_load("w2");
    rd(1'b0, 32'd4, 32'h34210100, "w2_addr4");
    rd(1'b0, 32'd4 + 32'd4096, 32'h34210100, "w2_wrap");
    rd(1'b0, 32'd6, 32'h34210100, "w2_addr6");
    rd(1'b0, 32'd0, 32'h3C010101, "w2_addr0");

    // Partial trailing word
    start_load();
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b0); send(8'hEE, 1'b1);
    @(negedge clk);
    chk("part_err", {31'b0, err_a}, 32'd0);
    align();
    align();
    rd(1'b0, 32'd4, 32'hEE000000, "part_mem1");
    rd(1'b0, 32'd0, 32'hAABBCCDD, "part_mem0");

    // Overflow on the 4-word instance
    start_load();
    for (int i = 0; i < 16; i++) send(8'(i + 1), 1'b0);
    @(negedge clk);
    chk("ovf_err_before", {31'b0, err_b}, 32'd0);
    send(8'h11, 1'b1);
    @(negedge clk);
    chk("ovf_err_after", {31'b0, err_b}, 32'd1);
    chk("ovf_done", {31'b0, done_b}, 32'd1);
    align();
    @(negedge clk);
    chk("ovf_err_sticky", {31'b0, err_b}, 32'd1);
    align();
    rd(1'b1, 32'd0, 32'h01020304, "ovf_b0");
    rd(1'b1, 32'd4, 32'h05060708, "ovf_b1");
    rd(1'b1, 32'd12, 32'h0D0E0F10, "ovf_b3");
    rd(1'b0, 32'd16, 32'h11000000, "ovf_a4");

    // Fetch blocked while busy; gapped valid
    v4 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    start_load();
    @(negedge clk);
    chk("gap_err_clear", {31'b0, err_b}, 32'd0);
    ce = 1'b1; addr = 32'd0;
    for (int i = 0; i < 4; i++) begin
      send(v4[i], i == 3);
      if (i < 3) begin
        @(negedge clk);
        chk("gap_inst_busy", inst_a, 32'h0);
        chk("gap_ready", {31'b0, rdy_a}, 32'd1);
        align();
      end
    end
    @(negedge clk);
    chk("gap_inst_done", inst_a, 32'h0);
    align();
    ce = 1'b0;
    rd(1'b0, 32'd0, 32'hDEADBEEF, "gap_mem0");

    // Reset mid-load keeps memory
    start_load();
    send(8'h12, 1'b0); send(8'h34, 1'b0);
    rst = 1'b1;
    align();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", {31'b0, busy_a}, 32'd0);
    align();
    rd(1'b0, 32'd0, 32'hDEADBEEF, "rst_mid_keep");
    start_load();
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
    finish_load("rld");
    rd(1'b0, 32'd0, 32'h11223344, "rld_mem0");

    // Restart mid-load; byte alongside ld_start dropped
    start_load();
    send(8'h99, 1'b0); send(8'h98, 1'b0);
    ld_start = 1'b1; ld_valid = 1'b1; ld_byte = 8'hFF;
    align();
    ld_start = 1'b0; ld_valid = 1'b0;
    send(8'h55, 1'b0); send(8'h66, 1'b0); send(8'h77, 1'b0); send(8'h88, 1'b1);
    finish_load("rs");
    rd(1'b0, 32'd0, 32'h55667788, "rs_mem0");
    rd(1'b0, 32'd4, 32'h05060708, "rs_mem1");

    // ld_start in DONE is ignored
    start_load();
    send(8'h01, 1'b1);
    ld_start = 1'b1;
    align();
    ld_start = 1'b0;
    @(negedge clk);
    chk("done_start_ign", {31'b0, busy_a}, 32'd0);
    align();

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
